// File: rtl/univ_reg_bank.sv
// univ_reg_bank: CHANNELS registers of WIDTH bits sharing one operation port
// (load, shift, rotate, count, clear), a registered carry flag, and a
// free-running scanner that steps through the channels for a single display.
// Build option: define UREG_SAT_EN to make INC/DEC saturate instead of wrap.
// Assumes WIDTH >= 2 so the shift and rotate slices are well formed.
module univ_reg_bank #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [$clog2(CHANNELS)-1:0] ch_sel,
    input  logic [2:0]                  op,
    input  logic [WIDTH-1:0]            din,
    input  logic                        ser_in,
    input  logic [$clog2(CHANNELS)-1:0] rd_sel,
    output logic [WIDTH-1:0]            dout,
    output logic                        carry,
    output logic                        zero,
    output logic [$clog2(CHANNELS)-1:0] scan_ch,
    output logic [WIDTH-1:0]            scan_data
);

    localparam int CH_BITS  = $clog2(CHANNELS);
    localparam int DIV_BITS = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [WIDTH-1:0]    ALL_ONES = '1;
    localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(SCAN_DIV - 1);
    localparam logic [CH_BITS-1:0]  CH_LAST  = CH_BITS'(CHANNELS - 1);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_INC  = 3'b100,
        OP_DEC  = 3'b101,
        OP_CLR  = 3'b110,
        OP_ROTL = 3'b111
    } op_e;

    logic [WIDTH-1:0]    regs [CHANNELS];
    logic                carry_q;
    logic [CH_BITS-1:0]  scan_q;
    logic [DIV_BITS-1:0] div_q;

    logic                ch_valid;
    logic                rd_valid;
    logic [WIDTH-1:0]    cur_val;
    logic [WIDTH-1:0]    nxt_val;
    logic                nxt_carry;
    logic                do_write;
    op_e                 op_dec;

    assign op_dec = op_e'(op);

    // When CHANNELS is a power of two every select code names a real channel,
    // so the range check collapses to a constant instead of a dead compare.
    if (CHANNELS == (1 << CH_BITS)) begin : g_full_range
        assign ch_valid = 1'b1;
        assign rd_valid = 1'b1;
    end else begin : g_part_range
        assign ch_valid = (ch_sel < CH_LAST + CH_BITS'(1));
        assign rd_valid = (rd_sel < CH_LAST + CH_BITS'(1));
    end

    // Current contents of the addressed channel, forced to zero when the
    // select is out of range so nothing downstream sees a bogus index.
    always_comb begin
        cur_val = '0;
        if (ch_valid) begin
            cur_val = regs[ch_sel];
        end
    end

    // Compute the post-operation value and carry for the addressed channel.
    always_comb begin
        nxt_val   = cur_val;
        nxt_carry = carry_q;
        case (op_dec)
            OP_HOLD: begin
                nxt_val   = cur_val;
                nxt_carry = carry_q;
            end
            OP_LOAD: begin
                nxt_val   = din;
                nxt_carry = 1'b0;
            end
            OP_SHL: begin
                nxt_val   = {cur_val[WIDTH-2:0], ser_in};
                nxt_carry = cur_val[WIDTH-1];
            end
            OP_SHR: begin
                nxt_val   = {ser_in, cur_val[WIDTH-1:1]};
                nxt_carry = cur_val[0];
            end
            OP_INC: begin
`ifdef UREG_SAT_EN
                if (cur_val == ALL_ONES) begin
                    nxt_val   = cur_val;
                    nxt_carry = 1'b1;
                end else begin
                    nxt_val   = cur_val + WIDTH'(1);
                    nxt_carry = 1'b0;
                end
`else
                nxt_val   = cur_val + WIDTH'(1);
                nxt_carry = (cur_val == ALL_ONES);
`endif
            end
            OP_DEC: begin
`ifdef UREG_SAT_EN
                if (cur_val == '0) begin
                    nxt_val   = cur_val;
                    nxt_carry = 1'b1;
                end else begin
                    nxt_val   = cur_val - WIDTH'(1);
                    nxt_carry = 1'b0;
                end
`else
                nxt_val   = cur_val - WIDTH'(1);
                nxt_carry = (cur_val == '0);
`endif
            end
            OP_CLR: begin
                nxt_val   = '0;
                nxt_carry = 1'b0;
            end
            OP_ROTL: begin
                nxt_val   = {cur_val[WIDTH-2:0], cur_val[WIDTH-1]};
                nxt_carry = cur_val[WIDTH-1];
            end
        endcase
    end

    assign do_write = enable & ch_valid;

    // Register bank and carry: only the addressed channel is ever written,
    // and an invalid select or deasserted enable leaves everything alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                regs[i] <= '0;
            end
            carry_q <= 1'b0;
        end else if (do_write) begin
            regs[ch_sel] <= nxt_val;
            carry_q      <= nxt_carry;
        end
    end

    // Display scanner: holds each channel for SCAN_DIV cycles regardless of
    // enable, then steps to the next one and wraps after the last channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            scan_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q  <= '0;
            scan_q <= (scan_q == CH_LAST) ? '0 : scan_q + CH_BITS'(1);
        end else begin
            div_q <= div_q + DIV_BITS'(1);
        end
    end

    // Read-side outputs are combinational from the registered state, so a
    // write shows up on dout and scan_data the cycle after its edge.
    always_comb begin
        dout = '0;
        if (rd_valid) begin
            dout = regs[rd_sel];
        end
    end

    assign carry     = carry_q;
    assign zero      = ch_valid && (cur_val == '0);
    assign scan_ch   = scan_q;
    assign scan_data = regs[scan_q];

endmodule

// File: tb/tb_univ_reg_bank.sv
// tb_univ_reg_bank: directed, self-checking bench for univ_reg_bank with
// WIDTH=4, CHANNELS=4, SCAN_DIV=4. Expectations follow UREG_SAT_EN if defined.
module tb_univ_reg_bank;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_DEC  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_ROTL = 3'b111;

`ifdef UREG_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] ch_sel;
    logic [2:0] op;
    logic [3:0] din;
    logic       ser_in;
    logic [1:0] rd_sel;
    logic [3:0] dout;
    logic       carry;
    logic       zero;
    logic [1:0] scan_ch;
    logic [3:0] scan_data;

    int checks = 0;
    int errors = 0;

    logic [3:0] model [4];
    int         exp_scan;

    univ_reg_bank #(
        .WIDTH   (4),
        .CHANNELS(4),
        .SCAN_DIV(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .ch_sel   (ch_sel),
        .op       (op),
        .din      (din),
        .ser_in   (ser_in),
        .rd_sel   (rd_sel),
        .dout     (dout),
        .carry    (carry),
        .zero     (zero),
        .scan_ch  (scan_ch),
        .scan_data(scan_data)
    );

    // 20 ns clock; rising edges at 10, 30, 50 ...
    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkChannel(input string tag, input logic [1:0] ch, input logic [7:0] expv);
        rd_sel = ch;
        #1;
        checkOutput(tag, 8'(dout), expv);
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] ch, input logic [2:0] o,
                                 input logic [3:0] d, input logic s);
        @(negedge clk);
        enable = en;
        ch_sel = ch;
        op     = o;
        din    = d;
        ser_in = s;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    // Watchdog so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        ch_sel = 2'd0;
        op     = OP_HOLD;
        din    = 4'h0;
        ser_in = 1'b0;
        rd_sel = 2'd0;
        #1 reset = 1'b1;
        #2;

        // Reset state, observed before any clock edge
        checkChannel("rst_ch0", 2'd0, 8'h00);
        checkChannel("rst_ch1", 2'd1, 8'h00);
        checkChannel("rst_ch2", 2'd2, 8'h00);
        checkChannel("rst_ch3", 2'd3, 8'h00);
        checkOutput("rst_carry", 8'(carry), 8'h00);
        checkOutput("rst_scan_ch", 8'(scan_ch), 8'h00);
        checkOutput("rst_scan_data", 8'(scan_data), 8'h00);
        checkOutput("rst_zero", 8'(zero), 8'h01);
        @(negedge clk);
        reset = 1'b0;

        // LOAD ch2 = A: not visible before the edge, visible after it
        @(negedge clk);
        enable = 1'b1;
        ch_sel = 2'd2;
        op     = OP_LOAD;
        din    = 4'hA;
        rd_sel = 2'd2;
        #1;
        checkOutput("load_pre_edge", 8'(dout), 8'h00);
        @(posedge clk);
        #1;
        enable = 1'b0;
        checkOutput("load_ch2", 8'(dout), 8'h0A);
        checkChannel("load_ch0_kept", 2'd0, 8'h00);
        checkChannel("load_ch1_kept", 2'd1, 8'h00);
        checkChannel("load_ch3_kept", 2'd3, 8'h00);
        checkOutput("load_carry", 8'(carry), 8'h00);

        // INC at all-ones, DEC at zero
        applyStimulus(1'b1, 2'd1, OP_LOAD, 4'hF, 1'b0);
        applyStimulus(1'b1, 2'd1, OP_INC, 4'h0, 1'b0);
        checkChannel("inc_top", 2'd1, SAT ? 8'h0F : 8'h00);
        checkOutput("inc_top_carry", 8'(carry), 8'h01);
        applyStimulus(1'b1, 2'd1, OP_LOAD, 4'h0, 1'b0);
        checkOutput("zero_flag_ch1", 8'(zero), 8'h01);
        applyStimulus(1'b1, 2'd1, OP_DEC, 4'h0, 1'b0);
        checkChannel("dec_bottom", 2'd1, SAT ? 8'h00 : 8'h0F);
        checkOutput("dec_bottom_carry", 8'(carry), 8'h01);

        // INC on ch3 while reading ch0: ch0 readout must not move
        applyStimulus(1'b1, 2'd3, OP_LOAD, 4'h5, 1'b0);
        rd_sel = 2'd0;
        applyStimulus(1'b1, 2'd3, OP_INC, 4'h0, 1'b0);
        checkOutput("inc_other_rd", 8'(dout), 8'h00);
        checkOutput("inc_mid_carry", 8'(carry), 8'h00);
        checkOutput("zero_flag_ch3", 8'(zero), 8'h00);
        checkChannel("inc_ch3", 2'd3, 8'h06);

        // Shifts and rotate
        applyStimulus(1'b1, 2'd0, OP_LOAD, 4'h9, 1'b0);
        applyStimulus(1'b1, 2'd0, OP_SHL, 4'h0, 1'b1);
        checkChannel("shl_val", 2'd0, 8'h03);
        checkOutput("shl_carry", 8'(carry), 8'h01);
        applyStimulus(1'b1, 2'd0, OP_SHR, 4'h0, 1'b0);
        checkChannel("shr_val", 2'd0, 8'h01);
        checkOutput("shr_carry", 8'(carry), 8'h01);
        applyStimulus(1'b1, 2'd0, OP_LOAD, 4'h8, 1'b0);
        applyStimulus(1'b1, 2'd0, OP_ROTL, 4'h0, 1'b0);
        checkChannel("rotl_val", 2'd0, 8'h01);
        checkOutput("rotl_carry", 8'(carry), 8'h01);

        // enable=0 holds registers and carry
        applyStimulus(1'b0, 2'd0, OP_LOAD, 4'h5, 1'b0);
        checkChannel("dis_ch0", 2'd0, 8'h01);
        checkChannel("dis_ch2", 2'd2, 8'h0A);
        checkChannel("dis_ch3", 2'd3, 8'h06);
        checkOutput("dis_carry", 8'(carry), 8'h01);

        // HOLD with enable leaves value and carry alone
        applyStimulus(1'b1, 2'd3, OP_HOLD, 4'hC, 1'b1);
        checkChannel("hold_ch3", 2'd3, 8'h06);
        checkOutput("hold_carry", 8'(carry), 8'h01);

        // Asynchronous reset mid-run, no clock edge needed
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkChannel("arst_ch0", 2'd0, 8'h00);
        checkChannel("arst_ch2", 2'd2, 8'h00);
        checkChannel("arst_ch3", 2'd3, 8'h00);
        checkOutput("arst_carry", 8'(carry), 8'h00);
        checkOutput("arst_scan_ch", 8'(scan_ch), 8'h00);

        // An op presented while reset is held must not execute
        enable = 1'b1;
        ch_sel = 2'd0;
        op     = OP_LOAD;
        din    = 4'h7;
        @(posedge clk);
        #1;
        checkChannel("rst_override", 2'd0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b0;
        checkChannel("first_op_after_rst", 2'd0, 8'h07);

        // CLR clears the value and the carry
        applyStimulus(1'b1, 2'd2, OP_LOAD, 4'hA, 1'b0);
        applyStimulus(1'b1, 2'd1, OP_LOAD, 4'hF, 1'b0);
        applyStimulus(1'b1, 2'd1, OP_INC, 4'h0, 1'b0);
        checkOutput("pre_clr_carry", 8'(carry), 8'h01);
        applyStimulus(1'b1, 2'd2, OP_CLR, 4'h0, 1'b0);
        checkChannel("clr_val", 2'd2, 8'h00);
        checkOutput("clr_carry", 8'(carry), 8'h00);
        checkChannel("clr_ch0_kept", 2'd0, 8'h07);

        // Scanner from a fresh reset: 4 cycles per channel, ignores enable
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            model[i] = 4'h0;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            enable = (k % 2 == 1);
            ch_sel = 2'((k / 2) % 4);
            op     = OP_LOAD;
            din    = 4'(k);
            @(posedge clk);
            #1;
            if (k % 2 == 1) begin
                model[(k / 2) % 4] = 4'(k);
            end
            exp_scan = (k / 4) % 4;
            checkOutput("scan_ch", 8'(scan_ch), 8'(exp_scan));
            checkOutput("scan_data", 8'(scan_data), 8'(model[exp_scan]));
        end
        enable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
